// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: registered fetch PC, small FIFO fetch buffer toward decode,
// redirect with flush and a one-cycle misaligned-target flag.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] addr_o,
    input  logic [31:0] instr_i,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        misaligned_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misaligned_q, misaligned_d;

    logic [31:0] buf_instr [DEPTH];
    logic [31:0] buf_pc    [DEPTH];

    logic pop;
    logic push;
    logic space;

    // Handshake decode and next-state; redirect overrides push and pop bookkeeping.
    always_comb begin
        pop          = (count_q != '0) && instr_ready_i;
        space        = (count_q < DEPTH_C) || pop;
        push         = !redirect_i && !halt_i && space;
        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        misaligned_d = 1'b0;
        if (redirect_i) begin
            // A coinciding pop is already consumed by decode; flush drops the rest.
            pc_d         = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            misaligned_d = |redirect_pc_i[1:0];
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Buffer storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr_q] <= instr_i;
            buf_pc[wr_ptr_q]    <= pc_q;
        end
    end

    // Head of buffer toward decode, forced to zero when empty.
    always_comb begin
        instr_valid_o = (count_q != '0);
        instr_o       = '0;
        pc_o          = '0;
        if (instr_valid_o) begin
            instr_o = buf_instr[rd_ptr_q];
            pc_o    = buf_pc[rd_ptr_q];
        end
    end

    assign addr_o       = pc_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// stimulus compared against a queue-based reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;

    logic [31:0] addr, instr_in, instr_out, pc_out;
    logic        valid, mis;
    logic [31:0] addr_w, instr_in_w, instr_out_w, pc_out_w;
    logic        valid_w, mis_w;

    int n_checks = 0;
    int n_errors = 0;

    localparam int unsigned MDEPTH = 2;

    logic [63:0] model_q [$];
    logic [31:0] m_pc;
    logic        m_mis;

    always #5 clk = ~clk;

    // Instruction ROM contents
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00: rom = 32'h0150_0093;
            32'h04: rom = 32'hFFF0_0093;
            32'h08: rom = 32'h0020_8133;
            32'h0c: rom = 32'h0041_01B3;
            32'h10: rom = 32'h0000_0213;
            32'h14: rom = 32'h0012_0213;
            32'h18: rom = 32'hFE52_1EE3;
            32'h1c: rom = 32'h0020_1093;
            default: rom = a ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign instr_in   = rom(addr);
    assign instr_in_w = rom(addr_w);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(MDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr_o(addr), .instr_i(instr_in), .halt_i(halt),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .instr_valid_o(valid),
        .instr_ready_i(ready), .instr_o(instr_out), .pc_o(pc_out), .misaligned_o(mis)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .addr_o(addr_w), .instr_i(instr_in_w), .halt_i(halt),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .instr_valid_o(valid_w),
        .instr_ready_i(ready), .instr_o(instr_out_w), .pc_o(pc_out_w), .misaligned_o(mis_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pulse reset for one cycle and release it at a falling edge.
    task automatic reset_release(input logic rdy);
        @(negedge clk);
        rst_n    = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        ready    = rdy;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: one clock edge worth of behaviour.
    task automatic model_step(input logic rd, input logic [31:0] rpc, input logic hl,
                              input logic rdy);
        logic popped;
        popped = (model_q.size() != 0) && rdy;
        if (rd) begin
            model_q.delete();
            m_pc  = {rpc[31:2], 2'b00};
            m_mis = (rpc[1:0] != 2'b00);
        end else begin
            m_mis = 1'b0;
            if (popped) void'(model_q.pop_front());
            if (!hl && model_q.size() < MDEPTH) begin
                model_q.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_compare();
        logic [63:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 64'd0;
        check_eq("rnd_addr", addr, m_pc);
        check_eq("rnd_valid", {31'd0, valid}, {31'd0, model_q.size() != 0});
        check_eq("rnd_pc", pc_out, head[63:32]);
        check_eq("rnd_instr", instr_out, head[31:0]);
        check_eq("rnd_mis", {31'd0, mis}, {31'd0, m_mis});
    endtask

    initial begin
        rst_n       = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        ready       = 1'b0;

        // Reset values
        @(negedge clk);
        check_eq("rst_addr", addr, 32'h0);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_instr", instr_out, 32'h0);
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_mis", {31'd0, mis}, 32'd0);
        check_eq("rst_addr_w", addr_w, 32'hFFFF_FFF8);

        // Streaming with decode always ready: no bubbles through 0x1c
        ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("stream_valid", {31'd0, valid}, 32'd1);
            check_eq("stream_pc", pc_out, 32'(4 * k));
            check_eq("stream_instr", instr_out, rom(32'(4 * k)));
        end

        // Backpressure: buffer fills, head holds, then drains in order
        reset_release(1'b0);
        repeat (5) @(negedge clk);
        check_eq("bp_valid", {31'd0, valid}, 32'd1);
        check_eq("bp_addr", addr, 32'h8);
        check_eq("bp_pc", pc_out, 32'h0);
        check_eq("bp_instr", instr_out, 32'h0150_0093);
        ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check_eq("bp_drain_pc", pc_out, 32'(4 * k));
        end

        // Redirect with a full buffer
        ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h1c;
        @(negedge clk);
        redirect = 1'b0;
        check_eq("redir_valid", {31'd0, valid}, 32'd0);
        check_eq("redir_addr", addr, 32'h1c);
        check_eq("redir_mis", {31'd0, mis}, 32'd0);
        @(negedge clk);
        check_eq("redir_valid2", {31'd0, valid}, 32'd1);
        check_eq("redir_pc", pc_out, 32'h1c);
        check_eq("redir_instr", instr_out, 32'h0020_1093);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h1e;
        @(negedge clk);
        redirect = 1'b0;
        check_eq("mis_pulse", {31'd0, mis}, 32'd1);
        check_eq("mis_addr", addr, 32'h1c);
        @(negedge clk);
        check_eq("mis_clear", {31'd0, mis}, 32'd0);
        check_eq("mis_pc", pc_out, 32'h1c);

        // PC wrap, then halt drains the buffer while addr holds
        reset_release(1'b1);
        @(negedge clk);
        check_eq("wrap_pc0", pc_out_w, 32'hFFFF_FFF8);
        @(negedge clk);
        check_eq("wrap_pc1", pc_out_w, 32'hFFFF_FFFC);
        @(negedge clk);
        check_eq("wrap_pc2", pc_out_w, 32'h0000_0000);
        check_eq("wrap_instr2", instr_out_w, 32'h0150_0093);
        halt = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("halt_valid_w", {31'd0, valid_w}, 32'd0);
        check_eq("halt_addr_w", addr_w, 32'h4);
        check_eq("halt_valid", {31'd0, valid}, 32'd0);
        check_eq("halt_addr", addr, 32'hc);
        halt = 1'b0;

        // Asynchronous reset between edges with two entries buffered
        reset_release(1'b0);
        repeat (3) @(negedge clk);
        check_eq("areset_pre_valid", {31'd0, valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("areset_valid", {31'd0, valid}, 32'd0);
        check_eq("areset_addr", addr, 32'h0);
        check_eq("areset_pc", pc_out, 32'h0);
        check_eq("areset_instr", instr_out, 32'h0);
        check_eq("areset_addr_w", addr_w, 32'hFFFF_FFF8);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        check_eq("restart_pc0", pc_out, 32'h0);
        check_eq("restart_instr0", instr_out, 32'h0150_0093);
        @(negedge clk);
        check_eq("restart_pc1", pc_out, 32'h4);

        // Randomized traffic against the reference model
        reset_release(1'b0);
        model_q.delete();
        m_pc  = 32'h0;
        m_mis = 1'b0;
        for (int i = 0; i < 400; i++) begin
            model_compare();
            ready    = ($urandom_range(0, 3) != 0);
            halt     = ($urandom_range(0, 7) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = 32'($urandom_range(0, 63));
                1:       redirect_pc = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
                default: redirect_pc = $urandom;
            endcase
            model_step(redirect, redirect_pc, halt, ready);
            @(negedge clk);
        end
        model_compare();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset (must be word-aligned).
REQ-002 SHALL have parameter DEPTH, default 2, meaning the fetch buffer entries (power of two, 2..8).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 addr_o  output  32  fetch address driven to instruction ROM.
REQ-007 instr_i  input  32  ROM data; combinational from addr_o, valid in the same cycle.
REQ-008 halt_i  input  1  suppresses new fetches; the buffer still drains.
REQ-009 redirect_i  input  1  one-cycle request to fetch from redirect_pc_i.
REQ-010 redirect_pc_i  input  32  redirect target address.
REQ-011 instr_valid_o  output  1  buffer head valid toward decode.
REQ-012 instr_ready_i  input  1  decode accepts the head.
REQ-013 instr_o  output  32  instruction at buffer head.
REQ-014 pc_o  output  32  address of instr_o.
REQ-015 misaligned_o  output  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Function
REQ-016 pc_q SHALL drive addr_o directly, with no combinational path from any input to addr_o.
REQ-017 Push: at each rising edge with redirect_i=0, halt_i=0, and space available, the unit SHALL write {pc_q, instr_i} into the buffer tail and set pc_q <= pc_q + 4.
REQ-018 Space SHALL be available when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-019 Pop: a transfer SHALL occur when instr_valid_o=1 and instr_ready_i=1; the head is then removed at that edge.
REQ-020 instr_valid_o SHALL equal (count != 0).
REQ-021 instr_o and pc_o SHALL come from the head entry, and SHALL read 0 when the buffer is empty.
REQ-022 While instr_valid_o=1 and instr_ready_i=0, instr_o and pc_o SHALL hold stable.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged, including at count == DEPTH.
REQ-024 Throughput SHALL be one instruction per cycle while instr_ready_i=1 and halt_i=0.
REQ-025 Latency SHALL be one edge: an instruction fetched at addr_o=A in cycle N appears on pc_o=A in cycle N+1.
REQ-026 Redirect SHALL have priority over push and pop: at the edge, the buffer is flushed (count=0), pc_q <= {redirect_pc_i[31:2], 2'b00}, and nothing is pushed.
REQ-027 A pop coinciding with redirect SHALL count as a completed transfer; the flush discards only the remaining entries.
REQ-028 If redirect_pc_i[1:0] != 0 when redirect_i=1, misaligned_o SHALL be 1 for the following cycle; otherwise misaligned_o SHALL be 0.
REQ-029 Redirect SHALL take effect even when halt_i=1: pc_q is updated, but no fetch occurs until halt_i=0.
REQ-030 pc_q SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-031 No state machine beyond pc_q, the buffer pointers and count, and the misaligned_o register SHALL exist; pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 While rst_n=0, outputs SHALL be: pc_q=addr_o=RESET_PC, count=0, instr_valid_o=0, instr_o=0, pc_o=0, misaligned_o=0.
REQ-033 Reset assertion SHALL clear the outputs immediately and asynchronously, including mid-operation with a full buffer.
REQ-034 The first push SHALL occur at the first rising edge after rst_n deasserts.

Verification
REQ-035 Connect the team's instruction ROM, release reset, and hold instr_ready_i=1 -> cycle 1: valid=1, pc_o=0x0, instr_o=32'h0150_0093; cycle 2: pc_o=0x4, instr_o=32'hFFF0_0093; no bubbles through 0x1c.
REQ-036 Hold instr_ready_i=0 for 5 cycles after reset -> count reaches 2, addr_o freezes at 0x8, and pc_o=0x0 stays stable; then raise ready -> pc_o = 0x0, 0x4, 0x8, 0xc on consecutive cycles.
REQ-037 With the buffer full, pulse redirect_i with redirect_pc_i=0x1c -> next cycle valid=0 and addr_o=0x1c; the cycle after: valid=1, pc_o=0x1c, instr_o=32'h0020_1093.
REQ-038 Redirect to 0x1e -> misaligned_o=1 for exactly one cycle, and the subsequent pc_o=0x1c.
REQ-039 RESET_PC=32'hFFFF_FFF8 with ready=1 -> pc_o = FFFF_FFF8, FFFF_FFFC, 0000_0000; with halt_i=1 and ready=1, the buffer drains to valid=0 and addr_o holds.
REQ-040 Assert rst_n=0 between edges with count=2 -> instr_valid_o=0 and addr_o=RESET_PC before the next edge; after release, the fetch sequence restarts at RESET_PC.
